// File: rtl/gene_char_packer.sv
// Streaming ASCII nucleotide packer: four bases per output byte at 2 bits each,
// with flush for short tails. Define GENE_PACK_LOWERCASE_EN to also accept acgt.
module gene_char_packer #(
  parameter logic [1:0] PAD_CODE  = 2'b00,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] In,
  input  logic       InValid,
  output logic       InReady,
  input  logic       Flush,
  output logic [7:0] Out,
  output logic [2:0] OutCount,
  output logic       OutValid,
  input  logic       OutReady,
  output logic       Err
);

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned SLOTS   = 4;
  localparam int unsigned BYTE_W  = CODE_W * SLOTS;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned COUNT_W = 3;

  logic [BYTE_W-1:0]  acc_q, acc_d, acc_ins;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] fill;
  logic [BYTE_W-1:0]  out_d;
  logic [COUNT_W-1:0] out_count_d;
  logic               out_valid_d;
  logic               err_d;
  logic               char_ok;
  logic [CODE_W-1:0]  char_code;

  // Accumulator always holds slot 0 in [7:6]; output ordering and padding
  // are applied only when the byte is emitted.
  function automatic logic [BYTE_W-1:0] emit_byte(input logic [BYTE_W-1:0] acc,
                                                  input logic [COUNT_W-1:0] n);
    logic [BYTE_W-1:0] b;
    logic [CODE_W-1:0] c;
    b = '0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      c = (i < int'(n)) ? acc[(BYTE_W-1-CODE_W*i) -: CODE_W] : PAD_CODE;
      if (MSB_FIRST) b[(BYTE_W-1-CODE_W*i) -: CODE_W] = c;
      else           b[(CODE_W*i) +: CODE_W]          = c;
    end
    return b;
  endfunction

  // Base character decode
  always_comb begin
    char_ok   = 1'b1;
    char_code = 2'b00;
    case (In)
      8'h41: char_code = 2'b00;
      8'h43: char_code = 2'b01;
      8'h47: char_code = 2'b10;
      8'h54: char_code = 2'b11;
`ifdef GENE_PACK_LOWERCASE_EN
      8'h61: char_code = 2'b00;
      8'h63: char_code = 2'b01;
      8'h67: char_code = 2'b10;
      8'h74: char_code = 2'b11;
`endif
      default: char_ok = 1'b0;
    endcase
  end

  assign InReady = ~OutValid | OutReady;

  // Next-state: store the accepted base first, then decide whether to emit
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = Out;
    out_count_d = OutCount;
    out_valid_d = OutValid;
    err_d       = 1'b0;
    acc_ins     = acc_q;
    fill        = COUNT_W'(cnt_q);

    if (OutValid && OutReady) out_valid_d = 1'b0;

    if (InReady) begin
      if (InValid) begin
        if (char_ok) begin
          case (cnt_q)
            2'd0:    acc_ins[7:6] = char_code;
            2'd1:    acc_ins[5:4] = char_code;
            2'd2:    acc_ins[3:2] = char_code;
            default: acc_ins[1:0] = char_code;
          endcase
          fill = fill + COUNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end

      if (fill == COUNT_W'(SLOTS) || (Flush && fill != '0)) begin
        out_valid_d = 1'b1;
        out_d       = emit_byte(acc_ins, fill);
        out_count_d = fill;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_ins;
        cnt_d = CNT_W'(fill);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      Out      <= '0;
      OutCount <= '0;
      OutValid <= 1'b0;
      Err      <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      Out      <= out_d;
      OutCount <= out_count_d;
      OutValid <= out_valid_d;
      Err      <= err_d;
    end
  end

endmodule

// File: tb/tb_gene_char_packer.sv
// Self-checking bench for gene_char_packer: queue-based reference model compared
// every cycle, plus literal expectations on the model's emitted bytes.
module tb_gene_char_packer;

  localparam logic [1:0] PAD      = 2'b00;
  localparam bit         MSBF     = 1'b1;

  logic       clk = 1'b0;
  logic       Rst;
  logic [7:0] In;
  logic       InValid;
  logic       InReady;
  logic       Flush;
  logic [7:0] Out;
  logic [2:0] OutCount;
  logic       OutValid;
  logic       OutReady;
  logic       Err;

  gene_char_packer #(.PAD_CODE(PAD), .MSB_FIRST(MSBF)) dut (
    .Clk(clk), .Rst(Rst), .In(In), .InValid(InValid), .InReady(InReady),
    .Flush(Flush), .Out(Out), .OutCount(OutCount), .OutValid(OutValid),
    .OutReady(OutReady), .Err(Err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of pending base codes, registered output view
  int         pend[$];
  logic       m_ov = 1'b0;
  logic [7:0] m_out = '0;
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  int         log_b[$];
  int         log_n[$];
  int         m_err_cnt = 0;

  function automatic int decode(input logic [7:0] ch);
    case (ch)
      8'h41: return 0;
      8'h43: return 1;
      8'h47: return 2;
      8'h54: return 3;
`ifdef GENE_PACK_LOWERCASE_EN
      8'h61: return 0;
      8'h63: return 1;
      8'h67: return 2;
      8'h74: return 3;
`endif
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] pack(input int q[$]);
    int b = 0;
    int c;
    for (int i = 0; i < 4; i++) begin
      c = (i < q.size()) ? q[i] : int'(PAD);
      if (MSBF) b = b + (c << (6 - 2 * i));
      else      b = b + (c << (2 * i));
    end
    return 8'(b);
  endfunction

  always @(posedge clk) begin
    if (Rst) begin
      pend.delete();
      m_ov = 1'b0; m_out = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      bit ready;
      bit new_err;
      int code;
      ready   = !m_ov || OutReady;
      new_err = 1'b0;
      if (m_ov && OutReady) m_ov = 1'b0;
      if (ready) begin
        if (InValid) begin
          code = decode(In);
          if (code >= 0) pend.push_back(code);
          else begin new_err = 1'b1; m_err_cnt++; end
        end
        if (pend.size() == 4 || (Flush && pend.size() > 0)) begin
          m_out = pack(pend);
          m_cnt = pend.size();
          m_ov  = 1'b1;
          log_b.push_back(int'(m_out));
          log_n.push_back(m_cnt);
          pend.delete();
        end
      end
      m_err = new_err;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  bit chk_en = 1'b0;
  int dut_xfers = 0;
  int dut_err_cnt = 0;
  int ir_low = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("inready", 32'(InReady), 32'(!m_ov || OutReady));
      check("outvalid", 32'(OutValid), 32'(m_ov));
      if (m_ov) begin
        check("out", 32'(Out), 32'(m_out));
        check("outcount", 32'(OutCount), 32'(m_cnt));
      end
      check("err", 32'(Err), 32'(m_err));
      if (OutValid && OutReady) dut_xfers++;
      if (Err) dut_err_cnt++;
      if (!InReady) ir_low++;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] ch, input logic fl);
    InValid = v; In = ch; Flush = fl;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0; Flush = 1'b0; In = 8'h00;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk_log(input string name, input int idx, input int eb, input int en);
    if (idx >= log_b.size()) begin
      check({name, "_present"}, 32'(log_b.size()), 32'(idx + 1));
    end else begin
      check({name, "_byte"}, 32'(log_b[idx]), 32'(eb));
      check({name, "_count"}, 32'(log_n[idx]), 32'(en));
    end
  endtask

  int base, ebase, dbase;

  initial begin
    Rst = 1'b1; In = '0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    repeat (2) @(posedge clk);
    #2 Rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_outcount", 32'(OutCount), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    @(posedge clk); #2;

    // ACTG -> 0x1E
    base = log_b.size(); dbase = dut_err_cnt;
    cyc(1, 8'h41, 0); cyc(1, 8'h43, 0); cyc(1, 8'h54, 0); cyc(1, 8'h47, 0);
    idle(2);
    chk_log("actg", base, 8'h1E, 4);
    check("actg_nbytes", 32'(log_b.size() - base), 32'd1);
    check("actg_no_err", 32'(dut_err_cnt - dbase), 32'd0);

    // TTTTAAAA back to back
    base = log_b.size(); ir_low = 0;
    for (int i = 0; i < 4; i++) cyc(1, 8'h54, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h41, 0);
    idle(2);
    chk_log("tttt", base, 8'hFF, 4);
    chk_log("aaaa", base + 1, 8'h00, 4);
    check("tttt_inready_low", 32'(ir_low), 32'd0);

    // GC + flush, then flush on empty
    base = log_b.size();
    cyc(1, 8'h47, 0); cyc(1, 8'h43, 0); cyc(0, 8'h00, 1);
    idle(1);
    cyc(0, 8'h00, 1);
    idle(2);
    chk_log("gc_flush", base, 8'h90, 2);
    check("empty_flush_nbytes", 32'(log_b.size() - base), 32'd1);

    // ACGN then T
    base = log_b.size(); dbase = dut_err_cnt; ebase = m_err_cnt;
    cyc(1, 8'h41, 0); cyc(1, 8'h43, 0); cyc(1, 8'h47, 0); cyc(1, 8'h4E, 0);
    cyc(1, 8'h54, 0);
    idle(2);
    chk_log("acgnt", base, 8'h1B, 4);
    check("acgnt_dut_err", 32'(dut_err_cnt - dbase), 32'd1);
    check("acgnt_model_err", 32'(m_err_cnt - ebase), 32'd1);

    // Partial G + flush together with a final valid char completing 4 bases
    base = log_b.size();
    cyc(1, 8'h47, 0); cyc(1, 8'h47, 0); cyc(1, 8'h41, 0); cyc(1, 8'h43, 1);
    idle(2);
    chk_log("flush4", base, 8'hA1, 4);
    check("flush4_nbytes", 32'(log_b.size() - base), 32'd1);

    // CCCC with OutReady low: held for 5 cycles
    base = log_b.size();
    OutReady = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 8'h43, 0);
    InValid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_inready", 32'(InReady), 32'd0);
      check("hold_out", 32'(Out), 32'h55);
    end
    cyc(1, 8'h41, 1);
    @(posedge clk); #2;
    OutReady = 1'b1;
    idle(1);
    @(negedge clk);
    check("release_inready", 32'(InReady), 32'd1);
    check("release_outvalid", 32'(OutValid), 32'd0);
    @(posedge clk); #2;
    chk_log("cccc", base, 8'h55, 4);
    check("cccc_nbytes", 32'(log_b.size() - base), 32'd1);

    // Mid-byte reset discards AC
    base = log_b.size();
    cyc(1, 8'h41, 0); cyc(1, 8'h43, 0);
    idle(0);
    Rst = 1'b1;
    @(posedge clk); #2;
    Rst = 1'b0;
    @(negedge clk);
    check("mrst_inready", 32'(InReady), 32'd1);
    check("mrst_outvalid", 32'(OutValid), 32'd0);
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) cyc(1, 8'h47, 0);
    idle(2);
    chk_log("gggg", base, 8'hAA, 4);
    check("gggg_nbytes", 32'(log_b.size() - base), 32'd1);

    // Lowercase handling
    base = log_b.size(); dbase = dut_err_cnt;
`ifdef GENE_PACK_LOWERCASE_EN
    cyc(1, 8'h61, 0); cyc(1, 8'h63, 0); cyc(1, 8'h67, 0); cyc(1, 8'h74, 0);
    idle(2);
    chk_log("lower", base, 8'h1B, 4);
    check("lower_err", 32'(dut_err_cnt - dbase), 32'd0);
`else
    cyc(1, 8'h61, 0); cyc(0, 8'h00, 1);
    idle(2);
    check("lower_err", 32'(dut_err_cnt - dbase), 32'd1);
    check("lower_nbytes", 32'(log_b.size() - base), 32'd0);
`endif

    idle(2);
    check("total_xfers", 32'(dut_xfers), 32'(log_b.size()));
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gene_char_packer.md
Name: gene_char_packer

Overview:
- Streaming nucleotide compressor and the inverse of the 2-bit-to-ASCII expander.
- Accepts one ASCII base character per cycle and packs four bases into one byte at 2 bits per base.
- Sits at the front of the compression datapath, between the raw genome byte stream and the compressed-byte sink.
- Valid/ready handshakes on both sides; explicit flush for sequence tails shorter than four bases.

Parameters:
- PAD_CODE, 2'b00, 2-bit code placed in unused slots of a flushed partial byte.
- MSB_FIRST, 1, 1 puts the first base in Out[7:6]; 0 puts the first base in Out[1:0].

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- In  input  8  ASCII base character.
- InValid  input  1  In is valid this cycle.
- InReady  output  1  block can accept In this cycle.
- Flush  input  1  request to emit the pending partial byte.
- Out  output  8  packed byte.
- OutCount  output  3  number of real bases in Out, 1..4.
- OutValid  output  1  Out and OutCount are valid.
- OutReady  input  1  sink accepts Out this cycle.
- Err  output  1  one-cycle pulse: an invalid character was consumed.

Behaviour:
- Encoding: 'A'(0x41)=00, 'C'(0x43)=01, 'G'(0x47)=10, 'T'(0x54)=11. Every other value is invalid.
- Handshakes:
  - Accept occurs when InValid & InReady. Output transfer occurs when OutValid & OutReady.
  - InReady = ~OutValid | OutReady. The same rule gates Flush.
- State: 2-bit shift accumulator of 8 bits plus fill counter Cnt, 0..3.
  - Idle: Cnt==0. Filling: Cnt 1..3. Holding: OutValid=1.
- Valid character accepted:
  - Its code is written to slot Cnt and Cnt increments.
  - If Cnt was 3: at the next edge Out = the completed byte, OutCount=4, OutValid=1, Cnt=0.
  - Latency from the 4th accepted base to OutValid: 1 cycle.
- Invalid character accepted:
  - Consumed and not stored; Cnt unchanged.
  - Err=1 for the following cycle only.
- Flush while InReady=1 and Cnt>0 (no char accepted the same cycle):
  - Out = stored codes with remaining slots = PAD_CODE.
  - OutCount = Cnt, OutValid=1, Cnt=0 at the next edge.
- Flush while Cnt==0: ignored, no output.
- Flush together with an accepted valid char: the char is stored first, then flushed.
  - If that completes 4 bases, a single byte with OutCount=4 is emitted (no extra empty byte).
- Flush together with an accepted invalid char: Err pulses and the flush uses the existing Cnt.
- Flush while InReady=0: ignored. The source must hold Flush until InReady.
- Output holding:
  - While OutValid & ~OutReady, Out and OutCount are held stable and no input is accepted.
  - OutValid falls after a transfer unless a new byte completes the same cycle, in which case a back-to-back load occurs.
  - Sustained throughput: 4 chars per output byte with no bubbles while OutReady=1.
- Reset, any time including mid-byte:
  - Cnt=0, accumulator cleared, Out=0, OutCount=0, OutValid=0, Err=0.
  - A partial byte in progress is discarded.
  - InReady=1 in the first cycle after reset.

Optional Feature:
- Macro: GENE_PACK_LOWERCASE_EN.
- Defined: 'a'(0x61), 'c'(0x63), 'g'(0x67), 't'(0x74) are also valid, with the same codes as uppercase.
- Undefined: lowercase characters are invalid; they are consumed and Err pulses.

Test Plan:
- Reset, OutReady=1, stream "ACTG" on 4 consecutive cycles -> one cycle later Out=0x1E, OutCount=4, OutValid=1 for 1 cycle; Err never asserted.
- Stream "TTTTAAAA" continuously, OutReady=1 -> Out=0xFF then Out=0x00 on consecutive output cycles, InReady constantly 1.
- Stream "GC" then Flush, PAD_CODE=00 -> Out=0x90, OutCount=2. Flush again with Cnt=0 -> no OutValid.
- Stream "ACGN" then "T" -> Err pulses once, after the 'N'; output Out=0x1B, OutCount=4 after the 'T'.
- Complete "CCCC" with OutReady=0 -> Out=0x55 held and InReady=0 for 5 cycles. Raise OutReady -> transfer, InReady returns to 1.
- Accept "AC", assert Rst for 1 cycle, then stream "GGGG" -> only Out=0xAA emitted. With GENE_PACK_LOWERCASE_EN defined, "acgt" -> Out=0x1B and no Err.
